// File: rtl/bsram_seq_pkg.sv
// Shared types and constants for the BSRAM replay sequencer and its skid buffer.
package bsram_seq_pkg;

  localparam int WIDTH  = 36;
  localparam int AW     = 9;
  localparam int AD_LSB = 5;
  localparam int RAM_AW = 14;
  localparam int PW     = 8;

  localparam logic [AW-1:0] ADDR_ONE = 9'd1;
  localparam logic [PW-1:0] PASS_ONE = 8'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    PLAY = 2'd2,
    DONE = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
    logic [PW-1:0]    pass;
  } skid_entry_t;

  function automatic logic [RAM_AW-1:0] ram_addr(input logic [AW-1:0] a);
    return {a, {AD_LSB{1'b0}}};
  endfunction

endpackage

// File: rtl/bsram_seq_skid.sv
// Two-entry skid FIFO absorbing RAM read data; exposes occupancy so the
// sequencer only issues reads it can park.
module bsram_seq_skid
  import bsram_seq_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_push,
  input  skid_entry_t i_din,
  input  logic        i_pop,
  output skid_entry_t o_head,
  output logic        o_valid,
  output logic [1:0]  o_occ
);

  skid_entry_t r_ent0;
  skid_entry_t r_ent1;
  logic [1:0]  r_occ;

  // Entry 0 is always the head; it only changes on a pop or a push into an empty buffer.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ent0 <= '0;
      r_ent1 <= '0;
      r_occ  <= 2'd0;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          if (r_occ == 2'd0) begin
            r_ent0 <= i_din;
          end else begin
            r_ent1 <= i_din;
          end
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_ent0 <= r_ent1;
          r_occ  <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_ent0 <= i_din;
          end else begin
            r_ent0 <= r_ent1;
            r_ent1 <= i_din;
          end
        end
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_head  = r_ent0;
  assign o_valid = (r_occ != 2'd0);
  assign o_occ   = r_occ;

endmodule

// File: rtl/bsram_replay_sequencer.sv
// Captures a sample block into a 512x36 single-port BSRAM and replays it REPLAYS+1 times.
// Optional feature macro: SEQ_CHECKSUM_EN (adds CHK_ERR fill-vs-pass XOR check).
module bsram_replay_sequencer
  import bsram_seq_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [AW-1:0]     LEN,
  input  logic [PW-1:0]     REPLAYS,
  input  logic [WIDTH-1:0]  S_DATA,
  input  logic              S_VALID,
  output logic              S_READY,
  output logic [WIDTH-1:0]  M_DATA,
  output logic              M_VALID,
  input  logic              M_READY,
  output logic              M_LAST,
  output logic [PW-1:0]     M_PASS,
  output logic              BUSY,
  output logic              DONE,
  output logic [WIDTH-1:0]  RAM_DI,
  output logic [RAM_AW-1:0] RAM_AD,
  output logic              RAM_WRE,
  output logic              RAM_CE,
  input  logic [WIDTH-1:0]  RAM_DO
`ifdef SEQ_CHECKSUM_EN
  ,
  output logic              CHK_ERR
`endif
);

  seq_state_t    r_state;
  seq_state_t    w_next;
  logic [AW-1:0] r_len;
  logic [AW-1:0] r_addr;
  logic [PW-1:0] r_replays;
  logic [PW-1:0] r_pass;
  logic          r_rd_done;
  logic          r_rd_pend;
  logic          r_rd_last;
  logic [PW-1:0] r_rd_pass;

  logic          w_start;
  logic          w_wr;
  logic          w_rd;
  logic          w_pop;
  logic          w_addr_end;
  logic          w_fill_end;
  logic          w_final_hs;
  logic          w_credit;
  logic          w_skid_valid;
  logic [1:0]    w_occ;
  skid_entry_t   w_head;
  skid_entry_t   w_push_ent;

  assign w_start    = (r_state == bsram_seq_pkg::IDLE) && START;
  assign w_wr       = (r_state == bsram_seq_pkg::FILL) && S_VALID;
  assign w_addr_end = (r_addr == r_len);
  assign w_fill_end = w_wr && w_addr_end;
  assign w_pop      = w_skid_valid && M_READY;
  // A word leaving this cycle frees its slot, which keeps reads back-to-back.
  assign w_credit   = ({1'b0, w_occ} + {2'b00, r_rd_pend}) < (3'd2 + {2'b00, w_pop});
  assign w_rd       = (r_state == bsram_seq_pkg::PLAY) && !r_rd_done && w_credit;
  assign w_final_hs = w_pop && w_head.last && (w_head.pass == r_replays);
  assign w_push_ent = '{data: RAM_DO, last: r_rd_last, pass: r_rd_pass};

  // State register.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state <= bsram_seq_pkg::IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      bsram_seq_pkg::IDLE: begin
        if (START) w_next = bsram_seq_pkg::FILL;
        else       w_next = bsram_seq_pkg::IDLE;
      end
      bsram_seq_pkg::FILL: begin
        if (w_fill_end) w_next = bsram_seq_pkg::PLAY;
        else            w_next = bsram_seq_pkg::FILL;
      end
      bsram_seq_pkg::PLAY: begin
        if (w_final_hs) w_next = bsram_seq_pkg::DONE;
        else            w_next = bsram_seq_pkg::PLAY;
      end
      bsram_seq_pkg::DONE: w_next = bsram_seq_pkg::IDLE;
      default:             w_next = bsram_seq_pkg::IDLE;
    endcase
  end

  // State-decoded outputs and RAM port drive.
  always_comb begin
    S_READY = 1'b0;
    BUSY    = 1'b0;
    DONE    = 1'b0;
    case (r_state)
      bsram_seq_pkg::FILL: begin
        S_READY = 1'b1;
        BUSY    = 1'b1;
      end
      bsram_seq_pkg::PLAY: BUSY = 1'b1;
      bsram_seq_pkg::DONE: DONE = 1'b1;
      default:             BUSY = 1'b0;
    endcase
    RAM_WRE = w_wr;
    if (w_wr) begin
      RAM_DI = S_DATA;
    end else begin
      RAM_DI = '0;
    end
    RAM_AD = ram_addr(r_addr);
    RAM_CE = 1'b1;
  end

  // Address/pass pointer, latched block parameters and in-flight read tag.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_len     <= '0;
      r_replays <= '0;
      r_addr    <= '0;
      r_pass    <= '0;
      r_rd_done <= 1'b0;
      r_rd_pend <= 1'b0;
      r_rd_last <= 1'b0;
      r_rd_pass <= '0;
    end else begin
      if (w_start) begin
        r_len     <= LEN;
        r_replays <= REPLAYS;
        r_addr    <= '0;
        r_pass    <= '0;
        r_rd_done <= 1'b0;
      end else if (w_wr) begin
        r_addr <= w_addr_end ? '0 : r_addr + ADDR_ONE;
      end else if (w_rd) begin
        if (w_addr_end) begin
          r_addr <= '0;
          if (r_pass == r_replays) begin
            r_rd_done <= 1'b1;
          end else begin
            r_pass <= r_pass + PASS_ONE;
          end
        end else begin
          r_addr <= r_addr + ADDR_ONE;
        end
      end
      r_rd_pend <= w_rd;
      r_rd_last <= w_addr_end;
      r_rd_pass <= r_pass;
    end
  end

  bsram_seq_skid u_skid (
    .i_clk   (CLK),
    .i_rst_n (RESET),
    .i_push  (r_rd_pend),
    .i_din   (w_push_ent),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_valid (w_skid_valid),
    .o_occ   (w_occ)
  );

  assign M_VALID = w_skid_valid;
  assign M_DATA  = w_head.data;
  assign M_LAST  = w_head.last && w_skid_valid;
  assign M_PASS  = w_head.pass;

`ifdef SEQ_CHECKSUM_EN
  logic [WIDTH-1:0] r_fill_xor;
  logic [WIDTH-1:0] r_pass_xor;
  logic             r_chk_err;

  // Fill XOR vs per-pass XOR of delivered words; mismatch latches until next START.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_fill_xor <= '0;
      r_pass_xor <= '0;
      r_chk_err  <= 1'b0;
    end else if (w_start) begin
      r_fill_xor <= '0;
      r_pass_xor <= '0;
      r_chk_err  <= 1'b0;
    end else begin
      if (w_wr) begin
        r_fill_xor <= r_fill_xor ^ S_DATA;
      end
      if (w_pop && w_head.last) begin
        r_pass_xor <= '0;
        if ((r_pass_xor ^ w_head.data) != r_fill_xor) begin
          r_chk_err <= 1'b1;
        end
      end else if (w_pop) begin
        r_pass_xor <= r_pass_xor ^ w_head.data;
      end
    end
  end

  assign CHK_ERR = r_chk_err;
`endif

endmodule
